game_clock_countdown: RTL and testbench

- Consumer end of the slow-clock path: takes the divided 1 Hz square wave, edge-detects it in the 50 MHz domain and runs the scoreboard game clock as an MM:SS countdown.
- Start/pause and load controls come from the panel buttons.
- Drives the display decoders and the end-of-period buzzer.

---
 rtl/game_clock_countdown.sv | 174 +++++++++++++++++
 tb/tb_game_clock_countdown.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_clock_countdown.sv
// -----------------------------------------------------------------------------
// game_clock_countdown
//
// Scoreboard game clock: counts down MM:SS on the rising edges of a 1 Hz tick.
// The start/pause and load panel buttons arrive as levels and are turned into
// single-cycle edges in the clock_in domain.
//
// Optional build macro: GAME_CLOCK_SYNC_EN
//   defined   - tick_in, start_pause_in and load_in pass through a 2-flop
//               synchronizer before edge detection (3-clock response latency)
//   undefined - inputs feed edge detection directly and must already be
//               synchronous to clock_in (1-clock response latency)
//
// Parameters:
//   START_MIN   minutes loaded at reset and on load (0-99)
//   START_SEC   seconds loaded at reset and on load (0-59)
//   BUZZER_SECS tick edges the buzzer stays on after expiry (0-15)
//
// Ports:
//   clock_in        system clock, 50 MHz
//   reset_n         asynchronous active-low reset
//   tick_in         1 Hz square wave, one second per rising edge
//   start_pause_in  button level, rising edge toggles run/pause
//   load_in         button level, rising edge reloads the start time and stops
//   minutes_out     current minutes, 0-99
//   seconds_out     current seconds, 0-59
//   running_out     high while running
//   expired_out     high once the clock has reached 00:00
//   buzzer_out      high while the buzzer countdown is non-zero
// -----------------------------------------------------------------------------
module game_clock_countdown #(
  parameter int START_MIN   = 10,
  parameter int START_SEC   = 0,
  parameter int BUZZER_SECS = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_pause_in,
  input  logic       load_in,
  output logic [6:0] minutes_out,
  output logic [5:0] seconds_out,
  output logic       running_out,
  output logic       expired_out,
  output logic       buzzer_out
);

  localparam logic [6:0] C_MIN  = 7'(START_MIN);
  localparam logic [5:0] C_SEC  = 6'(START_SEC);
  localparam logic [3:0] C_BUZZ = 4'(BUZZER_SECS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  // Bit order for the input bundle: [2] load, [1] start_pause, [0] tick.
  logic [2:0] w_in_raw;
  logic [2:0] w_in;
  logic [2:0] r_in_d;
  logic [2:0] w_edge;

  assign w_in_raw = {load_in, start_pause_in, tick_in};

`ifdef GAME_CLOCK_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  // Reset to 1 so that a level already high at reset release is not an edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_in_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = w_in_raw;
`endif

  // History resets high: inputs held high through reset produce no edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_in_d <= '1;
    end else begin
      r_in_d <= w_in;
    end
  end

  assign w_edge = w_in & ~r_in_d;

  logic w_load_e;
  logic w_sp_e;
  logic w_tick_e;

  assign w_load_e = w_edge[2];
  assign w_sp_e   = w_edge[1];
  assign w_tick_e = w_edge[0];

  state_t     r_state;
  logic [6:0] r_min;
  logic [5:0] r_sec;
  logic [3:0] r_buzz;
  logic       w_zero;

  assign w_zero = (r_min == 7'd0) && (r_sec == 6'd0);

  // Priority: load > start_pause > tick. Any lower-priority edge in the same
  // cycle as a higher-priority one is simply dropped.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_min   <= C_MIN;
      r_sec   <= C_SEC;
      r_buzz  <= 4'd0;
    end else if (w_load_e) begin
      r_state <= S_IDLE;
      r_min   <= C_MIN;
      r_sec   <= C_SEC;
      r_buzz  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sp_e) r_state <= S_RUN;
        end

        S_RUN: begin
          if (w_sp_e) begin
            r_state <= S_PAUSE;
          end else if (w_zero) begin
            // Started with 00:00 loaded: expire on the cycle after entry.
            r_state <= S_EXPIRED;
            r_buzz  <= C_BUZZ;
          end else if (w_tick_e) begin
            if (r_sec != 6'd0) begin
              r_sec <= r_sec - 6'd1;
              if ((r_min == 7'd0) && (r_sec == 6'd1)) begin
                r_state <= S_EXPIRED;
                r_buzz  <= C_BUZZ;
              end
            end else begin
              // Not zero and seconds are 0, so minutes are non-zero here.
              r_min <= r_min - 7'd1;
              r_sec <= 6'd59;
            end
          end
        end

        S_PAUSE: begin
          if (w_sp_e) r_state <= S_RUN;
        end

        S_EXPIRED: begin
          if (w_tick_e && (r_buzz != 4'd0)) r_buzz <= r_buzz - 4'd1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign minutes_out = r_min;
  assign seconds_out = r_sec;
  assign running_out = (r_state == S_RUN);
  assign expired_out = (r_state == S_EXPIRED);
  assign buzzer_out  = (r_buzz != 4'd0);

endmodule

// File: tb/tb_game_clock_countdown.sv
// -----------------------------------------------------------------------------
// tb_game_clock_countdown
//
// Two instances: dut (default 10:00 start) and dut2 (00:02 start, 3-tick
// buzzer). The stimulus process pushes the expected display state onto a
// queue after each button/tick action; a monitor on the falling clock edge
// pops each entry and compares it with the addressed instance.
// -----------------------------------------------------------------------------
module tb_game_clock_countdown;

`ifdef GAME_CLOCK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic tick, sp, ld;
  logic tick2, sp2, ld2;

  logic [6:0] min1, min2;
  logic [5:0] sec1, sec2;
  logic run1, run2, exp1, exp2, buz1, buz2;

  always #10 clk = ~clk;

  game_clock_countdown dut (
    .clock_in       (clk),
    .reset_n        (reset_n),
    .tick_in        (tick),
    .start_pause_in (sp),
    .load_in        (ld),
    .minutes_out    (min1),
    .seconds_out    (sec1),
    .running_out    (run1),
    .expired_out    (exp1),
    .buzzer_out     (buz1)
  );

  game_clock_countdown #(
    .START_MIN   (0),
    .START_SEC   (2),
    .BUZZER_SECS (3)
  ) dut2 (
    .clock_in       (clk),
    .reset_n        (reset_n),
    .tick_in        (tick2),
    .start_pause_in (sp2),
    .load_in        (ld2),
    .minutes_out    (min2),
    .seconds_out    (sec2),
    .running_out    (run2),
    .expired_out    (exp2),
    .buzzer_out     (buz2)
  );

  typedef struct packed {
    logic       which;
    logic [6:0] m;
    logic [5:0] s;
    logic       run;
    logic       exp;
    logic       buz;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got m=%0d s=%0d run=%0b exp=%0b buz=%0b, required m=%0d s=%0d run=%0b exp=%0b buz=%0b",
               nm, act[15:9], act[8:3], act[2], act[1], act[0],
               req[15:9], req[8:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic push(input bit which, input int m, input int s,
                      input bit r, input bit e, input bit b, input string nm);
    exp_t x;
    x.which = which;
    x.m     = 7'(m);
    x.s     = 6'(s);
    x.run   = r;
    x.exp   = e;
    x.buz   = b;
    sb_q.push_back(x);
    nm_q.push_back(nm);
  endtask

  // Monitor: one scoreboard entry per falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  x;
      string nm;
      logic [15:0] act;
      x  = sb_q.pop_front();
      nm = nm_q.pop_front();
      if (x.which) act = {min2, sec2, run2, exp2, buz2};
      else         act = {min1, sec1, run1, exp1, buz1};
      chk(nm, act, {x.m, x.s, x.run, x.exp, x.buz});
    end
  end

  // Raise the selected inputs long enough to be seen, drop them, and wait
  // until the low level has reached the edge-detect history.
  task automatic pulse(input bit which, input logic t, input logic s, input logic l);
    @(posedge clk); #1;
    if (which) begin tick2 = t; sp2 = s; ld2 = l; end
    else       begin tick  = t; sp  = s; ld  = l; end
    repeat (LAT) @(posedge clk);
    #1;
    if (which) begin tick2 = 1'b0; sp2 = 1'b0; ld2 = 1'b0; end
    else       begin tick  = 1'b0; sp  = 1'b0; ld  = 1'b0; end
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  int em, es, n;
  logic [5:0] prev;

  initial begin
    reset_n = 1'b0;
    tick = 1'b1; sp = 1'b0; ld = 1'b0;
    tick2 = 1'b0; sp2 = 1'b0; ld2 = 1'b0;

    // Reset held with tick high.
    repeat (2) @(posedge clk);
    #1;
    push(0, 10, 0, 0, 0, 0, "in_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    push(0, 10, 0, 0, 0, 0, "after_reset_tick_high");
    tick = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // Ticks without a start edge do nothing.
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    push(0, 10, 0, 0, 0, 0, "no_start");

    // Countdown over a minute boundary.
    pulse(0, 0, 1, 0);
    push(0, 10, 0, 1, 0, 0, "start");
    em = 10; es = 0;
    for (int i = 1; i <= 61; i++) begin
      pulse(0, 1, 0, 0);
      if (es > 0) es--;
      else begin em--; es = 59; end
      push(0, em, es, 1, 0, 0, "countdown");
    end
    push(0, 8, 59, 1, 0, 0, "countdown_end");

    // Pause / resume.
    pulse(0, 0, 0, 1);
    push(0, 10, 0, 0, 0, 0, "load");
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) pulse(0, 1, 0, 0);
    push(0, 9, 30, 1, 0, 0, "at_0930");
    pulse(0, 0, 1, 0);
    push(0, 9, 30, 0, 0, 0, "paused");
    for (int i = 0; i < 5; i++) begin
      pulse(0, 1, 0, 0);
      push(0, 9, 30, 0, 0, 0, "paused_tick");
    end
    pulse(0, 0, 1, 0);
    push(0, 9, 30, 1, 0, 0, "resumed");
    pulse(0, 1, 0, 0);
    push(0, 9, 29, 1, 0, 0, "resumed_tick");

    // Collision: load + start + tick while running at 05:17.
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 283; i++) pulse(0, 1, 0, 0);
    push(0, 5, 17, 1, 0, 0, "at_0517");
    pulse(0, 1, 1, 1);
    push(0, 10, 0, 0, 0, 0, "collide_load");
    // Start + tick together from IDLE: runs, time untouched.
    pulse(0, 1, 1, 0);
    push(0, 10, 0, 1, 0, 0, "collide_start_tick");

    // Async reset while running at 03:12.
    pulse(0, 0, 0, 1);
    pulse(0, 0, 1, 0);
    for (int i = 0; i < 408; i++) pulse(0, 1, 0, 0);
    push(0, 3, 12, 1, 0, 0, "at_0312");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {min1, sec1, run1, exp1, buz1}, {7'd10, 6'd0, 1'b0, 1'b0, 1'b0});
    #2;
    reset_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    push(0, 10, 0, 0, 0, 0, "after_async_reset");

    // Latency from tick rising to the seconds display changing.
    pulse(0, 0, 1, 0);
    @(posedge clk); #1;
    prev = sec1;
    tick = 1'b1;
    n = 0;
    while (sec1 == prev && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    tick = 1'b0;
    chk("tick_latency", 16'(n), 16'(LAT));
    repeat (LAT + 2) @(posedge clk);
    #1;
    push(0, 9, 59, 1, 0, 0, "latency_value");

    // Expiry on the 00:02 instance.
    push(1, 0, 2, 0, 0, 0, "e_idle");
    pulse(1, 0, 1, 0);
    push(1, 0, 2, 1, 0, 0, "e_start");
    pulse(1, 1, 0, 0);
    push(1, 0, 1, 1, 0, 0, "e_0001");
    pulse(1, 1, 0, 0);
    push(1, 0, 0, 0, 1, 1, "e_expired");
    pulse(1, 1, 0, 0);
    push(1, 0, 0, 0, 1, 1, "e_buzz2");
    pulse(1, 1, 0, 0);
    push(1, 0, 0, 0, 1, 1, "e_buzz1");
    pulse(1, 1, 0, 0);
    push(1, 0, 0, 0, 1, 0, "e_buzz0");
    pulse(1, 1, 0, 0);
    push(1, 0, 0, 0, 1, 0, "e_buzz_sat");
    pulse(1, 0, 1, 0);
    push(1, 0, 0, 0, 1, 0, "e_start_ignored");
    pulse(1, 0, 0, 1);
    push(1, 0, 2, 0, 0, 0, "e_reload");

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
